// File: rtl/i2c_hdmi_reg_target.sv
// ---------------------------------------------------------------------------
// i2c_hdmi_reg_target
//
// I2C target that stands in for the HDMI transmitter on the configuration bus.
// It decodes {address+R/W, sub-address, data...} transactions from the board's
// config master and exposes a byte-wide register write port and read port.
// SCL and SDA are oversampled on iCLK. Nothing is clocked by SCL, and the
// target never stretches the clock.
//
// Build option
//   I2C_TGT_READ_EN  When defined, read transactions (R/W=1) are served from
//                    iRD_DATA. When undefined, a read address byte is NACKed,
//                    the target ignores the rest of the transfer, and
//                    iRD_DATA is unused.
//
// Parameters
//   DEV_ADDR     7-bit target address (8'h72 write / 8'h73 read on the wire)
//   SYNC_STAGES  synchroniser depth on SCL and SDA (>= 2)
//   HOLD_CYC     iCLK cycles after a synced SCL fall before SDA_OE may change
//
// Ports
//   iCLK         system clock, at least 20x the SCL rate
//   iRST         asynchronous active-high reset
//   I2C_SCLK     bus clock from the master
//   I2C_SDAT_IN  bus data as seen at the pad
//   I2C_SDAT_OE  1 = pull SDA low, 0 = release (open-drain pad)
//   oWR_EN       one-cycle write strobe
//   oWR_ADDR     register address of the write
//   oWR_DATA     write data
//   oRD_ADDR     current register pointer
//   iRD_DATA     contents of register oRD_ADDR (combinational in the model)
//   oBUSY        high from START until STOP, whether or not we are addressed
//   oXFER_DONE   one-cycle pulse on a STOP that ends an addressed transaction
// ---------------------------------------------------------------------------
module i2c_hdmi_reg_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYC    = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  output logic       oWR_EN,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic [7:0] oRD_ADDR,
  input  logic [7:0] iRD_DATA,
  output logic       oBUSY,
  output logic       oXFER_DONE
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

`ifdef I2C_TGT_READ_EN
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, IGNORE,
    RDATA, RDATA_ACK
  } stateT;
`else
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, IGNORE
  } stateT;
`endif

  stateT state, stateNext;

  // Input synchronisers and edge history; the bus idles high.
  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic scl, sda, sclPrev, sdaPrev;
  logic sclRise, sclFall, startCond, stopCond;

  logic [2:0]    bitCnt;
  // Only seven bits are kept: the eighth received bit is taken straight from
  // sda, and on reads bit 7 goes onto the bus at load time.
  logic [6:0]    shreg;
  logic [7:0]    rxByte;
  logic [7:0]    ptr;
  logic          ackSeen;
  logic          matched;
  logic [HW-1:0] holdCnt;
  logic          oeTarget;

  // Strobes from the next-state logic to the datapath.
  logic bitInc, shiftIn, ackSet, ptrLoad, ptrInc, wrFire, matchSet, oeNext;
`ifdef I2C_TGT_READ_EN
  logic rdLoad, rdShift;
`else
  logic unusedRdData;
  assign unusedRdData = ^iRD_DATA;
`endif

  assign scl       = sclSync[SYNC_STAGES-1];
  assign sda       = sdaSync[SYNC_STAGES-1];
  assign sclRise   = scl & ~sclPrev;
  assign sclFall   = ~scl & sclPrev;
  assign startCond = scl & sclPrev & sdaPrev & ~sda;
  assign stopCond  = scl & sclPrev & ~sdaPrev & sda;
  assign rxByte    = {shreg, sda};
  assign oRD_ADDR  = ptr;

  // ---- state register ----
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // ---- next state and datapath strobes ----
  always_comb begin
    stateNext = state;
    bitInc    = 1'b0;
    shiftIn   = 1'b0;
    ackSet    = 1'b0;
    ptrLoad   = 1'b0;
    ptrInc    = 1'b0;
    wrFire    = 1'b0;
    matchSet  = 1'b0;
    oeNext    = 1'b0;   // every SCL fall releases SDA unless a state claims it
`ifdef I2C_TGT_READ_EN
    rdLoad    = 1'b0;
    rdShift   = 1'b0;
`endif
    if (startCond) begin
      stateNext = ADDR;
    end else if (stopCond) begin
      stateNext = IDLE;
    end else begin
      case (state)
        ADDR: if (sclRise) begin
          shiftIn = 1'b1;
          bitInc  = 1'b1;
          if (bitCnt == 3'd7) begin
            if (rxByte[7:1] != DEV_ADDR) begin
              stateNext = IGNORE;
`ifdef I2C_TGT_READ_EN
            end else begin
              matchSet  = 1'b1;
              stateNext = ADDR_ACK;
            end
`else
            end else if (rxByte[0]) begin
              stateNext = IGNORE;
            end else begin
              matchSet  = 1'b1;
              stateNext = ADDR_ACK;
            end
`endif
          end
        end
        SUB: if (sclRise) begin
          shiftIn = 1'b1;
          bitInc  = 1'b1;
          if (bitCnt == 3'd7) begin
            ptrLoad   = 1'b1;
            stateNext = SUB_ACK;
          end
        end
        WDATA: if (sclRise) begin
          shiftIn = 1'b1;
          bitInc  = 1'b1;
          if (bitCnt == 3'd7) begin
            wrFire    = 1'b1;
            stateNext = WDATA_ACK;
          end
        end
        // The first fall after the 8th bit opens the ACK slot; the fall after
        // the 9th rise closes it and selects what the next slot carries.
        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          if (sclRise) begin
            ackSet = 1'b1;
          end else if (sclFall) begin
            if (!ackSeen) begin
              oeNext = 1'b1;
            end else if (state == ADDR_ACK) begin
`ifdef I2C_TGT_READ_EN
              if (shreg[0]) begin
                rdLoad    = 1'b1;
                oeNext    = ~iRD_DATA[7];
                stateNext = RDATA;
              end else begin
                stateNext = SUB;
              end
`else
              stateNext = SUB;
`endif
            end else if (state == SUB_ACK) begin
              stateNext = WDATA;
            end else begin
              ptrInc    = 1'b1;
              stateNext = WDATA;
            end
          end
        end
`ifdef I2C_TGT_READ_EN
        RDATA: begin
          if (sclRise) begin
            bitInc = 1'b1;
            if (bitCnt == 3'd7) stateNext = RDATA_ACK;
          end else if (sclFall) begin
            rdShift = 1'b1;
            oeNext  = ~shreg[6];
          end
        end
        RDATA_ACK: begin
          if (sclRise) begin
            if (!sda) begin
              ackSet = 1'b1;
              ptrInc = 1'b1;
            end else begin
              stateNext = IGNORE;
            end
          end else if (sclFall && ackSeen) begin
            rdLoad    = 1'b1;
            oeNext    = ~iRD_DATA[7];
            stateNext = RDATA;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // ---- datapath, bus drive and status ----
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sclSync     <= '1;
      sdaSync     <= '1;
      sclPrev     <= 1'b1;
      sdaPrev     <= 1'b1;
      bitCnt      <= 3'd0;
      shreg       <= 7'd0;
      ptr         <= 8'd0;
      ackSeen     <= 1'b0;
      matched     <= 1'b0;
      holdCnt     <= '0;
      oeTarget    <= 1'b0;
      I2C_SDAT_OE <= 1'b0;
      oWR_EN      <= 1'b0;
      oWR_ADDR    <= 8'd0;
      oWR_DATA    <= 8'd0;
      oBUSY       <= 1'b0;
      oXFER_DONE  <= 1'b0;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], I2C_SCLK};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], I2C_SDAT_IN};
      sclPrev <= scl;
      sdaPrev <= sda;

      if (startCond)   bitCnt <= 3'd0;
      else if (bitInc) bitCnt <= bitCnt + 3'd1;

      if (shiftIn) shreg <= rxByte[6:0];
`ifdef I2C_TGT_READ_EN
      else if (rdLoad)  shreg <= iRD_DATA[6:0];
      else if (rdShift) shreg <= {shreg[5:0], 1'b0};
`endif

      if (ptrLoad)     ptr <= rxByte;
      else if (ptrInc) ptr <= ptr + 8'd1;

      if (stateNext != state) ackSeen <= 1'b0;
      else if (ackSet)        ackSeen <= 1'b1;

      oWR_EN <= wrFire;
      if (wrFire) begin
        oWR_ADDR <= ptr;
        oWR_DATA <= rxByte;
      end

      // START/STOP happen with SCL high, where the target never drives;
      // releasing at once also cancels any drive still in the hold window.
      if (startCond || stopCond) begin
        holdCnt     <= '0;
        I2C_SDAT_OE <= 1'b0;
      end else if (sclFall) begin
        holdCnt  <= HOLD_LD;
        oeTarget <= oeNext;
      end else if (holdCnt != '0) begin
        holdCnt <= holdCnt - HOLD_ONE;
        if (holdCnt == HOLD_ONE) I2C_SDAT_OE <= oeTarget;
      end

      if (startCond)     oBUSY <= 1'b1;
      else if (stopCond) oBUSY <= 1'b0;

      oXFER_DONE <= stopCond & matched;
      if (startCond || stopCond) matched <= 1'b0;
      else if (matchSet)         matched <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_hdmi_reg_target.sv
module tb_i2c_hdmi_reg_target;

  localparam int Q = 100;  // quarter SCL period; iCLK period is 10

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       sclM, sdaM;
  logic       sdaBus;
  logic       oe;
  logic       oWR_EN;
  logic [7:0] oWR_ADDR, oWR_DATA, oRD_ADDR, iRD_DATA;
  logic       oBUSY, oXFER_DONE;

  int nChk  = 0;
  int nPass = 0;
  int nFail = 0;

  logic [7:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  int         xferCnt = 0;
  logic       oeSeen  = 1'b0;

  assign sdaBus   = sdaM & ~oe;
  assign iRD_DATA = ~oRD_ADDR;

  always #5 iCLK = ~iCLK;

  i2c_hdmi_reg_target dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .I2C_SCLK    (sclM),
    .I2C_SDAT_IN (sdaBus),
    .I2C_SDAT_OE (oe),
    .oWR_EN      (oWR_EN),
    .oWR_ADDR    (oWR_ADDR),
    .oWR_DATA    (oWR_DATA),
    .oRD_ADDR    (oRD_ADDR),
    .iRD_DATA    (iRD_DATA),
    .oBUSY       (oBUSY),
    .oXFER_DONE  (oXFER_DONE)
  );

  always @(negedge iCLK) begin
    if (oWR_EN) begin
      wrAddrQ.push_back(oWR_ADDR);
      wrDataQ.push_back(oWR_DATA);
    end
    if (oXFER_DONE) xferCnt = xferCnt + 1;
    if (oe) oeSeen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    wrAddrQ.delete();
    wrDataQ.delete();
    xferCnt = 0;
    oeSeen  = 1'b0;
  endtask

  task automatic xferBit(input logic b, output logic s);
    sdaM = b;    #(Q);
    sclM = 1'b1; #(Q);
    s = sdaBus;  #(Q);
    sclM = 1'b0; #(Q);
  endtask

  task automatic i2cStart();
    sdaM = 1'b1; #(Q);
    sclM = 1'b1; #(Q);
    sdaM = 1'b0; #(Q);
    sclM = 1'b0; #(Q);
  endtask

  task automatic i2cStop();
    sdaM = 1'b0; #(Q);
    sclM = 1'b1; #(Q);
    sdaM = 1'b1; #(2*Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) xferBit(b[i], s);
    xferBit(1'b1, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      xferBit(1'b1, s);
      d[i] = s;
    end
    xferBit(~ack, s);
  endtask

  task automatic writeScenario(input string pfx);
    logic a;
    clearMon();
    i2cStart();
    chk({pfx, "_busy_start"}, oBUSY, 1'b1);
    sendByte(8'h72, a); chk({pfx, "_ack_addr"}, a, 1'b1);
    sendByte(8'h41, a); chk({pfx, "_ack_sub"}, a, 1'b1);
    sendByte(8'h10, a); chk({pfx, "_ack_data"}, a, 1'b1);
    i2cStop();
    chk({pfx, "_wr_count"}, wrAddrQ.size(), 1);
    if (wrAddrQ.size() >= 1) begin
      chk({pfx, "_wr_addr"}, wrAddrQ[0], 8'h41);
      chk({pfx, "_wr_data"}, wrDataQ[0], 8'h10);
    end
    chk({pfx, "_xfer_done"}, xferCnt, 1);
    chk({pfx, "_busy_stop"}, oBUSY, 1'b0);
    chk({pfx, "_ptr"}, oRD_ADDR, 8'h42);
    chk({pfx, "_sda_released"}, oe, 1'b0);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    sclM = 1'b1;
    sdaM = 1'b1;
    iRST = 1'b1;
    repeat (5) @(posedge iCLK);
    #1 iRST = 1'b0;
    repeat (5) @(posedge iCLK);
    #1;
    chk("rst_oe",    oe,         1'b0);
    chk("rst_wr_en", oWR_EN,     1'b0);
    chk("rst_waddr", oWR_ADDR,   8'h00);
    chk("rst_wdata", oWR_DATA,   8'h00);
    chk("rst_ptr",   oRD_ADDR,   8'h00);
    chk("rst_busy",  oBUSY,      1'b0);
    chk("rst_done",  oXFER_DONE, 1'b0);

    // Plain write
    writeScenario("s1");

    // Burst with pointer wrap
    clearMon();
    i2cStart();
    sendByte(8'h72, a); chk("s2_ack_addr", a, 1'b1);
    sendByte(8'hFE, a); chk("s2_ack_sub",  a, 1'b1);
    sendByte(8'hAA, a); chk("s2_ack_d0",   a, 1'b1);
    sendByte(8'hBB, a); chk("s2_ack_d1",   a, 1'b1);
    sendByte(8'hCC, a); chk("s2_ack_d2",   a, 1'b1);
    i2cStop();
    chk("s2_wr_count", wrAddrQ.size(), 3);
    if (wrAddrQ.size() == 3) begin
      chk("s2_wa0", wrAddrQ[0], 8'hFE); chk("s2_wd0", wrDataQ[0], 8'hAA);
      chk("s2_wa1", wrAddrQ[1], 8'hFF); chk("s2_wd1", wrDataQ[1], 8'hBB);
      chk("s2_wa2", wrAddrQ[2], 8'h00); chk("s2_wd2", wrDataQ[2], 8'hCC);
    end
    chk("s2_ptr", oRD_ADDR, 8'h01);
    chk("s2_xfer_done", xferCnt, 1);

    // Another device's address
    clearMon();
    i2cStart();
    sendByte(8'h70, a); chk("s3_nack_addr", a, 1'b0);
    sendByte(8'h41, a); chk("s3_nack_b0",   a, 1'b0);
    sendByte(8'h10, a); chk("s3_nack_b1",   a, 1'b0);
    chk("s3_busy_mid", oBUSY, 1'b1);
    i2cStop();
    chk("s3_busy_stop", oBUSY, 1'b0);
    chk("s3_oe_never", oeSeen, 1'b0);
    chk("s3_wr_count", wrAddrQ.size(), 0);
    chk("s3_xfer_done", xferCnt, 0);
    chk("s3_ptr", oRD_ADDR, 8'h01);

    // Combined read: 72 98 Sr 73 rd(ACK) rd(NACK) P
    clearMon();
    i2cStart();
    sendByte(8'h72, a); chk("s4_ack_addr", a, 1'b1);
    sendByte(8'h98, a); chk("s4_ack_sub",  a, 1'b1);
    i2cStart();
    oeSeen = 1'b0;
`ifdef I2C_TGT_READ_EN
    sendByte(8'h73, a); chk("s4_ack_raddr", a, 1'b1);
    readByte(1'b1, d);  chk("s4_rd0", d, 8'h67);
    readByte(1'b0, d);  chk("s4_rd1", d, 8'h66);
    i2cStop();
    chk("s4_ptr", oRD_ADDR, 8'h99);
    chk("s4_xfer_done", xferCnt, 1);
    chk("s4_oe_released", oe, 1'b0);
`else
    sendByte(8'h73, a); chk("s5_nack_raddr", a, 1'b0);
    readByte(1'b1, d);  chk("s5_rd0", d, 8'hFF);
    readByte(1'b0, d);  chk("s5_rd1", d, 8'hFF);
    i2cStop();
    chk("s5_oe_never", oeSeen, 1'b0);
    chk("s5_wr_count", wrAddrQ.size(), 0);
    chk("s5_ptr", oRD_ADDR, 8'h98);
`endif

    // Reset while the target is driving the ACK of a byte
    clearMon();
    i2cStart();
    sendByte(8'h72, a); chk("s6_ack_addr", a, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      xferBit(d[0] ^ d[0] ^ ((8'h41 >> i) & 1) ? 1'b1 : 1'b0, s);
    end
    sdaM = 1'b1; #(Q);
    sclM = 1'b1; #(Q);
    chk("s6_oe_before", oe, 1'b1);
    iRST = 1'b1;
    #1;
    chk("s6_oe_async", oe, 1'b0);
    #(Q);
    sclM = 1'b0; #(Q);
    sdaM = 1'b0; #(Q);
    iRST = 1'b0; #(Q);
    sclM = 1'b1; #(Q);
    sdaM = 1'b1; #(2*Q);
    chk("s6_wr_count", wrAddrQ.size(), 0);
    chk("s6_ptr_reset", oRD_ADDR, 8'h00);
    chk("s6_busy", oBUSY, 1'b0);
    writeScenario("s6r");

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
